// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/valid memory handshake,
// presents them to the decoder with valid/ready, and computes the next PC on acceptance.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  PC_MUX_Select,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [1:0]  fsm_state
);

    // Handshake: a transfer to the decoder happens on a rising edge where
    // instr_valid and instr_ready are both 1; instruction is stable while instr_valid=1.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic        timeout;
    logic        accept;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc;
    assign pc_plus4   = pc + 32'd4;
    assign fsm_state  = state;
    assign accept     = (state == S_HOLD) && instr_valid && instr_ready;
    // A response arriving in the last WAIT cycle takes priority over the timeout.
    assign timeout    = (state == S_WAIT) && !imem_valid && (wait_cnt == WAIT_LAST);
    assign branch_off = {{14{instruction[15]}}, instruction[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (PC_MUX_Select)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = branch_taken ? (pc_plus4 + branch_off) : pc_plus4;
            2'b10:   next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
            default: next_pc = jr_target & 32'hFFFF_FFFC;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_valid)   state_nxt = S_HOLD;
                else if (timeout) state_nxt = S_REQ;
            end
            S_HOLD: if (accept) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instruction <= 32'd0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= 16'd0;
        end else begin
            state     <= state_nxt;
            fetch_err <= timeout;
            case (state)
                S_REQ: wait_cnt <= 16'd0;
                S_WAIT: begin
                    if (imem_valid) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                    end else if (!timeout) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
